// File: rtl/darkuart_pkg.sv
// Shared definitions for the darkuart receive monitor and a future transmitter.
// Holds the frame size, receiver state encoding and baud divider helpers.
package darkuart_pkg;

    localparam int unsigned NBITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned ck_hz, input int unsigned baud);
        return ck_hz / baud;
    endfunction

    function automatic int unsigned calc_half(input int unsigned ck_hz, input int unsigned baud);
        return calc_div(ck_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/darkuart_fifo.sv
// Byte FIFO with a registered head-of-queue output (first-word fall-through).
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module darkuart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written when full.
    assign do_push = push && (!full || do_pop);
    assign rdata   = rdata_q;

    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        rdata_d = rdata_q;
        // Preload the next head so the output stays a plain register.
        if (do_push && (wptr_q == rptr_d)) begin
            rdata_d = wdata;
        end else if (wptr_d != rptr_d) begin
            rdata_d = mem_q[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/darkuart_mon.sv
// 8N1 UART receive monitor: synchronizer, frame FSM, sticky error flags,
// accepted-byte counter and a byte FIFO presented on a valid/ready port.
module darkuart_mon
    import darkuart_pkg::*;
#(
    parameter int unsigned CK_HZ = 100000000,
    parameter int unsigned BAUD  = 115200,
    parameter int unsigned DEPTH = 16
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        RXD,
    output logic [7:0]  RDATA,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        FERR,
    output logic        OVR,
    input  logic        CLR,
    output logic [15:0] FRAMES
);

    localparam int unsigned DIV  = calc_div(CK_HZ, BAUD);
    localparam int unsigned HALF = calc_half(CK_HZ, BAUD);
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW   = $clog2(NBITS);

    logic [1:0]       sync_q;
    logic             rxs;
    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic             ferr_q, ovr_q;
    logic [15:0]      frames_q;
    logic             expire, push, ferr_set;
    logic             pop, push_ok, ovr_set;
    logic             fifo_full, fifo_empty;

    assign rxs    = sync_q[1];
    assign expire = (cnt_q == '0);

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RXD};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    cnt_d   = CW'(HALF - 1);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rxs) begin
                    bit_d   = '0;
                    cnt_d   = CW'(DIV - 1);
                    state_d = StData;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rxs, shift_q[NBITS-1:1]};
                    cnt_d   = CW'(DIV - 1);
                    if (bit_q == BW'(NBITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            StStop: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxs) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else begin
                    ferr_set = 1'b1;
                    state_d  = StBreak;
                end
            end
            StBreak: begin
                // Held-low line: one error, then wait for idle before rearming.
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign RVALID  = !fifo_empty;
    assign pop     = RVALID && RREADY;
    assign push_ok = push && (!fifo_full || pop);
    assign ovr_set = push && fifo_full && !pop;

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            // Set events take priority over a simultaneous clear.
            if (ferr_set) begin
                ferr_q <= 1'b1;
            end else if (CLR) begin
                ferr_q <= 1'b0;
            end
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (CLR) begin
                ovr_q <= 1'b0;
            end
            if (push_ok) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    assign FERR   = ferr_q;
    assign OVR    = ovr_q;
    assign FRAMES = frames_q;

    darkuart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NBITS)
    ) u_fifo (
        .clk   (XCLK),
        .rst_n (XRES),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (RDATA),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_darkuart_mon.sv
// Directed bench for darkuart_mon: expected bytes queued by the stimulus,
// popped and compared by an independent monitor on each accepted transfer.
module tb_darkuart_mon;

    localparam int unsigned CK_HZ = 100_000_000;
    localparam int unsigned BAUD  = 1_000_000;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DIV   = 100;

    logic        XCLK = 1'b0;
    logic        XRES;
    logic        RXD;
    logic [7:0]  RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        FERR;
    logic        OVR;
    logic        CLR;
    logic [15:0] FRAMES;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         t_start = 0;
    int         t_pop   = 0;
    logic [7:0] exp_q[$];

    darkuart_mon #(
        .CK_HZ (CK_HZ),
        .BAUD  (BAUD),
        .DEPTH (DEPTH)
    ) dut (
        .XCLK   (XCLK),
        .XRES   (XRES),
        .RXD    (RXD),
        .RDATA  (RDATA),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .FERR   (FERR),
        .OVR    (OVR),
        .CLR    (CLR),
        .FRAMES (FRAMES)
    );

    always #5 XCLK = ~XCLK;

    always @(posedge XCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge XCLK);
            #1;
            if (XRES && RVALID && RREADY) begin
                t_pop = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", RDATA);
                end else begin
                    chk("rdata", {24'd0, RDATA}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at a negedge; leaves RXD at the stop level so frames chain directly.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        RXD     = 1'b0;
        t_start = cyc;
        repeat (DIV) @(negedge XCLK);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            repeat (DIV) @(negedge XCLK);
        end
        RXD = stop;
        repeat (DIV) @(negedge XCLK);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge XCLK);
            k++;
        end
        @(negedge XCLK);
        #2;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        CLR = 1'b1;
        @(negedge XCLK);
        CLR = 1'b0;
        @(negedge XCLK);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, {24'd0, RDATA}, 32'h0);
        chk({tag, "_rvalid"}, {31'd0, RVALID}, 32'h0);
        chk({tag, "_ferr"}, {31'd0, FERR}, 32'h0);
        chk({tag, "_ovr"}, {31'd0, OVR}, 32'h0);
        chk({tag, "_frames"}, {16'd0, FRAMES}, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        XRES   = 1'b0;
        RXD    = 1'b1;
        RREADY = 1'b0;
        CLR    = 1'b0;
        repeat (3) @(negedge XCLK);
        chk_reset_outputs("reset");
        XRES = 1'b1;
        repeat (5) @(negedge XCLK);

        // Single byte with consumer ready.
        RREADY = 1'b1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain(200);
        d = t_pop - t_start;
        chk("latency_window", {31'd0, (d >= 950 && d <= 956)}, 32'h1);
        chk("pulse_rvalid", {31'd0, RVALID}, 32'h0);
        chk("frames_after_55", {16'd0, FRAMES}, 32'd1);

        // Short low glitch on an idle line.
        RXD = 1'b0;
        repeat (30) @(negedge XCLK);
        RXD = 1'b1;
        repeat (200) @(negedge XCLK);
        chk("glitch_rvalid", {31'd0, RVALID}, 32'h0);
        chk("glitch_ferr", {31'd0, FERR}, 32'h0);
        chk("glitch_frames", {16'd0, FRAMES}, 32'd1);

        // Framing error, clear, then a good byte.
        send_frame(8'hA5, 1'b0);
        RXD = 1'b1;
        repeat (10) @(negedge XCLK);
        chk("ferr_set", {31'd0, FERR}, 32'h1);
        chk("ferr_frames", {16'd0, FRAMES}, 32'd1);
        chk("ferr_rvalid", {31'd0, RVALID}, 32'h0);
        pulse_clr();
        chk("ferr_clr", {31'd0, FERR}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain(200);
        chk("frames_after_3c", {16'd0, FRAMES}, 32'd2);

        // Overrun: 17 back-to-back bytes into a 16-deep FIFO.
        RREADY = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        repeat (50) @(negedge XCLK);
        #2;
        chk("ovr_set", {31'd0, OVR}, 32'h1);
        chk("ovr_frames", {16'd0, FRAMES}, 32'd18);
        chk("ovr_rvalid", {31'd0, RVALID}, 32'h1);
        chk("ovr_head", {24'd0, RDATA}, 32'h00);
        chk("ovr_ferr", {31'd0, FERR}, 32'h0);
        @(negedge XCLK);
        RREADY = 1'b1;
        repeat (16) @(negedge XCLK);
        #2;
        chk("burst_empty", {31'd0, RVALID}, 32'h0);
        chk("burst_drained", exp_q.size(), 0);
        chk("ovr_sticky", {31'd0, OVR}, 32'h1);

        // Reset during data bit 4 of 0x77.
        RXD = 1'b0;
        repeat (DIV) @(negedge XCLK);
        for (int i = 0; i < 4; i++) begin
            RXD = (i != 3);
            repeat (DIV) @(negedge XCLK);
        end
        RXD = 1'b1;
        repeat (DIV / 2) @(negedge XCLK);
        XRES = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        repeat (5) @(negedge XCLK);
        XRES = 1'b1;
        repeat (1200) @(negedge XCLK);
        chk("post_reset_rvalid", {31'd0, RVALID}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain(200);
        chk("post_reset_frames", {16'd0, FRAMES}, 32'd1);

        // Line held low: one error only, then recovery.
        RXD = 1'b0;
        repeat (1200) @(negedge XCLK);
        chk("break_ferr", {31'd0, FERR}, 32'h1);
        pulse_clr();
        repeat (800) @(negedge XCLK);
        chk("break_single_err", {31'd0, FERR}, 32'h0);
        chk("break_frames", {16'd0, FRAMES}, 32'd1);
        chk("break_rvalid", {31'd0, RVALID}, 32'h0);
        RXD = 1'b1;
        repeat (50) @(negedge XCLK);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_drain(200);
        chk("ff_frames", {16'd0, FRAMES}, 32'd2);
        chk("ff_ferr", {31'd0, FERR}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
